// File: rtl/alu_vector_checker_if.sv
// Vector bus between the checker (master) and the ALU under test (slave).
// The checker drives op/num1 and reads the ALU's 32-bit result back.
interface alu_vector_checker_if;
  logic [2:0]  op;
  logic [7:0]  num1;
  logic [31:0] results;

  modport master (output op, output num1, input results);
  modport slave  (input op, input num1, output results);
endinterface

// File: rtl/alu_vector_checker.sv
// Sweeps every op/num1 vector into an ALU, samples the settled result and compares it
// with an internal reference; reports pass, a saturating error count and the first failure.
module alu_vector_checker #(
  parameter int NUM_LAST      = 255,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  alu_vector_checker_if.master alu,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [2:0]           first_err_op,
  output logic [7:0]           first_err_num,
  output logic [31:0]          first_err_got,
  output logic [31:0]          first_err_exp
);

  localparam logic [7:0] LP_NUM_LAST = 8'(NUM_LAST);
  localparam logic [3:0] LP_SETTLE   = 4'(SETTLE_CYCLES);
  localparam logic [31:0] LP_A       = 32'h1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [7:0]  r_num1;
  logic [3:0]  r_wait;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [15:0] r_err_count;
  logic [2:0]  r_first_op;
  logic [7:0]  r_first_num;
  logic [31:0] r_first_got;
  logic [31:0] r_first_exp;

  logic [31:0] w_b;
  logic [31:0] w_exp;
  logic        w_mismatch;
  logic        w_last;

  // Reference model, evaluated from the registered vector so it matches what the ALU sees.
  always_comb begin
    w_b   = {24'h0, r_num1};
    w_exp = 32'h0;
    case (r_op)
      3'd0:    w_exp = LP_A + w_b;
      3'd1:    w_exp = LP_A - w_b;
      3'd2:    w_exp = LP_A & w_b;
      3'd3:    w_exp = LP_A | w_b;
      3'd4:    w_exp = ~LP_A;
      3'd5:    w_exp = {31'h0, (LP_A < w_b)};
      default: w_exp = 32'h0;
    endcase
  end

  assign w_mismatch = (alu.results != w_exp);
  assign w_last     = (r_op == 3'd7) && (r_num1 == LP_NUM_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= 3'd0;
      r_num1      <= 8'd0;
      r_wait      <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 16'd0;
      r_first_op  <= 3'd0;
      r_first_num <= 8'd0;
      r_first_got <= 32'd0;
      r_first_exp <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_APPLY;
            r_op        <= 3'd0;
            r_num1      <= 8'd0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 16'd0;
            r_first_op  <= 3'd0;
            r_first_num <= 8'd0;
            r_first_got <= 32'd0;
            r_first_exp <= 32'd0;
          end
        end
        S_APPLY: begin
          r_wait  <= LP_SETTLE;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait <= 4'd1) r_state <= S_CHECK;
          else                r_wait  <= r_wait - 4'd1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            if (r_err_count == 16'd0) begin
              r_first_op  <= r_op;
              r_first_num <= r_num1;
              r_first_got <= alu.results;
              r_first_exp <= w_exp;
            end
          end
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= !w_mismatch && (r_err_count == 16'd0);
          end else begin
            r_state <= S_APPLY;
            r_op    <= r_op + 3'd1;
            if (r_op == 3'd7) r_num1 <= r_num1 + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu.op        = r_op;
  assign alu.num1      = r_num1;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign first_err_op  = r_first_op;
  assign first_err_num = r_first_num;
  assign first_err_got = r_first_got;
  assign first_err_exp = r_first_exp;

endmodule

// File: tb/tb_alu_vector_checker.sv
// Directed bench: three checker instances (short sweep, full sweep, long settle) each
// driving a behavioural ALU with selectable faults; expected values are hand-computed.
module tb_alu_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_bc = 1'b1;
  logic start_v [3];
  logic done_v  [3];
  logic busy_v  [3];
  logic pass_v  [3];
  logic [15:0] err_v [3];
  logic [2:0]  fop_v [3];
  logic [7:0]  fnum_v [3];
  logic [31:0] fgot_v [3];
  logic [31:0] fexp_v [3];

  int mode_a = 0;
  logic glitch = 1'b0;
  int n_checks = 0;
  int n_pass = 0;

  alu_vector_checker_if if_a ();
  alu_vector_checker_if if_b ();
  alu_vector_checker_if if_c ();

  function automatic logic [31:0] alu_golden(input logic [2:0] op, input logic [7:0] n);
    logic [31:0] b;
    b = {24'h0, n};
    case (op)
      3'd0:    return 32'h1 + b;
      3'd1:    return 32'h1 - b;
      3'd2:    return 32'h1 & b;
      3'd3:    return 32'h1 | b;
      3'd4:    return 32'hFFFF_FFFE;
      3'd5:    return (b > 32'h1) ? 32'h1 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    if_a.results = alu_golden(if_a.op, if_a.num1);
    if (mode_a == 1 && if_a.op == 3'd4) if_a.results = 32'h0;
    if (mode_a == 2 && if_a.op == 3'd5 && if_a.num1 == 8'd1) if_a.results = 32'h55;
    if (mode_a == 3 && if_a.op == 3'd5 && if_a.num1 == 8'd2) if_a.results = 32'h55;
  end

  always_comb begin
    if_b.results = alu_golden(if_b.op, if_b.num1);
    if (if_b.op == 3'd1) if_b.results = 32'h1 - {24'h0, if_b.num1} + 32'h1;
  end

  assign if_c.results = alu_golden(if_c.op, if_c.num1) ^ (glitch ? 32'hDEAD_BEEF : 32'h0);

  alu_vector_checker #(.NUM_LAST(3), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_v[0]), .alu(if_a.master),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
    .first_err_op(fop_v[0]), .first_err_num(fnum_v[0]),
    .first_err_got(fgot_v[0]), .first_err_exp(fexp_v[0]));

  alu_vector_checker #(.NUM_LAST(255), .SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst_bc), .start(start_v[1]), .alu(if_b.master),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
    .first_err_op(fop_v[1]), .first_err_num(fnum_v[1]),
    .first_err_got(fgot_v[1]), .first_err_exp(fexp_v[1]));

  alu_vector_checker #(.NUM_LAST(0), .SETTLE_CYCLES(4)) dut_c (
    .clk(clk), .rst(rst_bc), .start(start_v[2]), .alu(if_c.master),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
    .first_err_op(fop_v[2]), .first_err_num(fnum_v[2]),
    .first_err_got(fgot_v[2]), .first_err_exp(fexp_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Pulses start, then counts edges from the start edge to the edge where done is seen.
  task automatic run_sweep(input int d, input bit repulse, output int cycles,
                           output logic busy0, output logic done0, output logic [15:0] err0);
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    busy0 = busy_v[d];
    done0 = done_v[d];
    err0  = err_v[d];
    cycles = -1;
    for (int c = 1; c <= 8000; c++) begin
      if (d == 2) glitch = ((c - 1) % 6 >= 1) && ((c - 1) % 6 <= 4);
      start_v[d] = (repulse && c == 2);
      @(posedge clk);
      #1;
      if (done_v[d]) begin
        cycles = c;
        break;
      end
    end
    start_v[d] = 1'b0;
    glitch = 1'b0;
  endtask

  int cyc;
  logic b0, d0;
  logic [15:0] e0;
  bit seen;

  initial begin
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'h0, busy_v[0]}, 32'h0);
    check("reset_done", {31'h0, done_v[0]}, 32'h0);
    check("reset_pass", {31'h0, pass_v[0]}, 32'h0);
    check("reset_err", {16'h0, err_v[0]}, 32'h0);
    check("reset_op_num", {21'h0, if_a.op, if_a.num1}, 32'h0);
    check("reset_first_got", fgot_v[0], 32'h0);
    check("reset_first_exp", fexp_v[0], 32'h0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_bc = 1'b0;

    // Golden sweep with a start re-pulse while in WAIT
    run_sweep(0, 1'b1, cyc, b0, d0, e0);
    check("gold_busy_at_start", {31'h0, b0}, 32'h1);
    check("gold_cycles", cyc, 96);
    check("gold_pass", {31'h0, pass_v[0]}, 32'h1);
    check("gold_err", {16'h0, err_v[0]}, 32'h0);
    check("gold_busy_done", {31'h0, busy_v[0]}, 32'h0);

    // op4 forced to zero, restarting from DONE
    mode_a = 1;
    run_sweep(0, 1'b0, cyc, b0, d0, e0);
    check("op4_done_drop", {31'h0, d0}, 32'h0);
    check("op4_cycles", cyc, 96);
    check("op4_err", {16'h0, err_v[0]}, 32'h4);
    check("op4_pass", {31'h0, pass_v[0]}, 32'h0);
    check("op4_first_op", {29'h0, fop_v[0]}, 32'h4);
    check("op4_first_num", {24'h0, fnum_v[0]}, 32'h0);
    check("op4_first_got", fgot_v[0], 32'h0);
    check("op4_first_exp", fexp_v[0], 32'hFFFF_FFFE);

    // Restart clears counters; reset at num1=2 aborts
    mode_a = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    check("restart_err_clear", {16'h0, err_v[0]}, 32'h0);
    check("restart_first_clear", {29'h0, fop_v[0]}, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (if_a.num1 == 8'd2) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_num1_2", {31'h0, seen}, 32'h1);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    check("midrst_busy", {31'h0, busy_v[0]}, 32'h0);
    check("midrst_done", {31'h0, done_v[0]}, 32'h0);
    check("midrst_op_num", {21'h0, if_a.op, if_a.num1}, 32'h0);
    check("midrst_err", {16'h0, err_v[0]}, 32'h0);
    run_sweep(0, 1'b0, cyc, b0, d0, e0);
    check("postrst_cycles", cyc, 96);
    check("postrst_pass", {31'h0, pass_v[0]}, 32'h1);

    // op5 reference: 0 at num1=1, 1 at num1=2
    mode_a = 2;
    run_sweep(0, 1'b0, cyc, b0, d0, e0);
    check("op5n1_err", {16'h0, err_v[0]}, 32'h1);
    check("op5n1_first_op", {29'h0, fop_v[0]}, 32'h5);
    check("op5n1_first_num", {24'h0, fnum_v[0]}, 32'h1);
    check("op5n1_first_got", fgot_v[0], 32'h55);
    check("op5n1_first_exp", fexp_v[0], 32'h0);
    mode_a = 3;
    run_sweep(0, 1'b0, cyc, b0, d0, e0);
    check("op5n2_first_num", {24'h0, fnum_v[0]}, 32'h2);
    check("op5n2_first_exp", fexp_v[0], 32'h1);

    // Full sweep with op1 off by one
    run_sweep(1, 1'b0, cyc, b0, d0, e0);
    check("full_cycles", cyc, 6144);
    check("full_err", {16'h0, err_v[1]}, 32'd256);
    check("full_pass", {31'h0, pass_v[1]}, 32'h0);
    check("full_first_op", {29'h0, fop_v[1]}, 32'h1);
    check("full_first_num", {24'h0, fnum_v[1]}, 32'h0);
    check("full_first_got", fgot_v[1], 32'h2);
    check("full_first_exp", fexp_v[1], 32'h1);

    // Long settle, single num1, results glitched throughout WAIT
    run_sweep(2, 1'b0, cyc, b0, d0, e0);
    check("settle4_cycles", cyc, 48);
    check("settle4_err", {16'h0, err_v[2]}, 32'h0);
    check("settle4_pass", {31'h0, pass_v[2]}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_vector_checker.md
Name: alu_vector_checker

Overview:
- Self-checking stimulus/response engine: the driving end of the 3-bit op / 8-bit operand / 32-bit result ALU test interface.
- Sweeps every opcode (0..7) across the operand range and presents each vector on op/num1.
- Waits for the result to settle, samples it and compares it against an internal reference model.
- Reports a pass flag, an error count and the first failing vector. Used on-board (LED/seven-segment readout) and in simulation benches.

Parameters:
- NUM_LAST, 255: last num1 value swept; sweep runs 0..NUM_LAST, 8 ops per value (legal range 0..255).
- SETTLE_CYCLES, 1: cycles between applying a vector and sampling results (legal range 1..15).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; starts a sweep when in IDLE or DONE.
- op  output  3  opcode driven to the ALU under test.
- num1  output  8  operand driven to the ALU under test.
- results  input  32  ALU output, sampled in the CHECK state.
- busy  output  1  high in APPLY/WAIT/CHECK.
- done  output  1  high while in DONE.
- pass  output  1  in DONE, high iff err_count==0; 0 elsewhere.
- err_count  output  16  mismatch count; saturates at 16'hFFFF.
- first_err_op  output  3  op of the first mismatch.
- first_err_num  output  8  num1 of the first mismatch.
- first_err_got  output  32  results value captured at the first mismatch.
- first_err_exp  output  32  expected value at the first mismatch.

Behaviour:
- Reset: state=IDLE. op, num1, busy, done, pass, err_count and all first_err_* = 0. Reset mid-sweep aborts immediately to this state.
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Outputs: all outputs are registered; op/num1 only change on entry to APPLY.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE + start=1:
  - clear err_count and first_err_*;
  - load op=0, num1=0 in the same edge;
  - go to APPLY.
- APPLY: 1 cycle; vector is stable on op/num1. Load the wait counter with SETTLE_CYCLES, then go to WAIT.
- WAIT: stay exactly SETTLE_CYCLES cycles, then go to CHECK.
- CHECK: 1 cycle; sample results and compare with expected.
  - On mismatch, increment err_count (saturating).
  - If err_count was 0 before the increment, latch first_err_op/num/got/exp.
  - Advance op (op=7 wraps to 0 and increments num1).
  - If op=7 and num1=NUM_LAST, go to DONE; otherwise update op/num1 and go to APPLY.
- Vector period: SETTLE_CYCLES+2 cycles. Full sweep: 8*(NUM_LAST+1)*(SETTLE_CYCLES+2) cycles from the start edge to the done rising edge.
- start while busy is ignored. A start in DONE restarts the sweep. pass/done drop on the restart edge.
- Reference model: A=32'h1, B={24'h0,num1}, 32-bit modular arithmetic.
  - op0: A+B
  - op1: A-B (wraps; e.g. num1=8'hFF gives 32'hFFFFFF02)
  - op2: A&B
  - op3: A|B
  - op4: ~A = 32'hFFFFFFFE
  - op5: 1 if A<B (unsigned), else 0
  - op6, op7: 32'h0
- Reference model evaluation: expected is computed combinationally from the registered op/num1.

Test Plan:
- Golden ALU model attached, NUM_LAST=3, SETTLE_CYCLES=1, start pulsed at edge t: done rises at edge t+96; pass=1; err_count=0; busy low from edge t+96.
- Same config, model forces results=0 when op=3'b100: err_count=4, pass=0, first_err_op=4, first_err_num=0, first_err_got=0, first_err_exp=32'hFFFFFFFE.
- Model returns A-B+1 for op1, NUM_LAST=255: err_count=256, first_err_num=0, first_err_got=32'h2, first_err_exp=32'h1. Also check op5 expected values: 0 at num1=1, 1 at num1=2.
- rst asserted for 1 cycle mid-sweep (num1=2): next cycle state IDLE, op=0, num1=0, busy=0, err_count=0. A fresh start then completes normally.
- start re-pulsed during WAIT: ignored, sweep length unchanged. start pulsed in DONE: counters cleared, sweep repeats with identical timing.
- SETTLE_CYCLES=4, NUM_LAST=0: done at edge t+48. results is sampled only in CHECK, so a glitch injected during WAIT causes no error.
